// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one single-port RAM between CPU (m0), DMA (m1) and debug (m2)
// with a per-owner burst limit, optional CPU priority at idle arbitration, and a 1-cycle read return path.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CPU_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    input  logic              m2_req,
    input  logic              m2_we,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    output logic              m2_gnt,
    output logic              m2_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_hold
);
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state, state_nx;
    logic [1:0]        owner, owner_nx, last_owner, last_nx, rd_id;
    logic [BW-1:0]     beat_cnt, beat_nx;
    logic              rd_pend, sel_we;
    logic [2:0]        req, gnt, others;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, rdata_q;

    // first requester in r scanning base+1, base+2, base+3 (mod 3)
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [2:0] r);
        logic [1:0] p;
        int k;
        p = base;
        for (int i = 3; i >= 1; i--) begin
            k = (int'(base) + i) % 3;
            if (r[2'(k)]) p = 2'(k);
        end
        return p;
    endfunction

    assign req    = {m2_req, m1_req, m0_req};
    assign others = req & ~(3'b001 << owner);
    assign gnt    = state == OWN ? req & (3'b001 << owner) : 3'b000;
    assign {m2_gnt, m1_gnt, m0_gnt} = gnt;
    assign cpu_hold = m0_req & ~m0_gnt;

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_owner;
        beat_nx  = beat_cnt;
        if (state == IDLE) begin
            if (|req) begin
                state_nx = OWN;
                owner_nx = (CPU_PRIO != 0 && m0_req) ? 2'd0 : rr_pick(last_owner, req);
                beat_nx  = '0;
            end
        end else if (!req[owner]) begin
            // owner released the bus: hand over without a bubble, or go idle
            if (|others) begin
                owner_nx = rr_pick(owner, others);
                beat_nx  = '0;
            end else begin
                state_nx = IDLE;
                last_nx  = owner;
            end
        end else if (beat_cnt == LAST_BEAT && |others) begin
            owner_nx = rr_pick(owner, others);
            beat_nx  = '0;
        end else begin
            beat_nx = beat_cnt == LAST_BEAT ? beat_cnt : beat_cnt + 1'b1;
        end
    end

    assign sel_we    = owner == 2'd0 ? m0_we    : owner == 2'd1 ? m1_we    : m2_we;
    assign sel_addr  = owner == 2'd0 ? m0_addr  : owner == 2'd1 ? m1_addr  : m2_addr;
    assign sel_wdata = owner == 2'd0 ? m0_wdata : owner == 2'd1 ? m1_wdata : m2_wdata;

    assign ram_en    = |gnt;
    assign ram_we    = ram_en & sel_we;
    assign ram_addr  = ram_en ? sel_addr : '0;
    assign ram_wdata = ram_en ? sel_wdata : '0;

    // RAM data is live during the return cycle and held afterwards
    assign rdata     = rd_pend ? ram_rdata : rdata_q;
    assign m0_rvalid = rd_pend & (rd_id == 2'd0);
    assign m1_rvalid = rd_pend & (rd_id == 2'd1);
    assign m2_rvalid = rd_pend & (rd_id == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            beat_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_id      <= 2'd0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            beat_cnt   <= beat_nx;
            rd_pend    <= ram_en & ~ram_we;
            if (ram_en & ~ram_we) rd_id <= owner;
            if (rd_pend) rdata_q <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench with a read-return scoreboard for mem_bus_arbiter,
// plus a CPU-priority instance for the idle-arbitration override.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  req = 3'b000, we = 3'b000, gnt, rvalid;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
    logic        ram_en, ram_we, cpu_hold;
    logic [31:0] mem [256];

    logic [2:0]  p_req = 3'b000, p_gnt, p_rvalid;
    logic [31:0] p_rdata, p_ram_addr, p_ram_wdata;
    logic        p_ram_en, p_ram_we, p_hold;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .CPU_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]),
        .m2_req(req[2]), .m2_we(we[2]), .m2_addr(addr[2]), .m2_wdata(wdata[2]), .m2_gnt(gnt[2]), .m2_rvalid(rvalid[2]),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .cpu_hold(cpu_hold)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .CPU_PRIO(1)) dut_prio (
        .clk(clk), .rst(rst),
        .m0_req(p_req[0]), .m0_we(1'b1), .m0_addr(32'h0), .m0_wdata(32'h0), .m0_gnt(p_gnt[0]), .m0_rvalid(p_rvalid[0]),
        .m1_req(p_req[1]), .m1_we(1'b1), .m1_addr(32'h0), .m1_wdata(32'h0), .m1_gnt(p_gnt[1]), .m1_rvalid(p_rvalid[1]),
        .m2_req(p_req[2]), .m2_we(1'b1), .m2_addr(32'h0), .m2_wdata(32'h0), .m2_gnt(p_gnt[2]), .m2_rvalid(p_rvalid[2]),
        .rdata(p_rdata), .ram_en(p_ram_en), .ram_we(p_ram_we), .ram_addr(p_ram_addr), .ram_wdata(p_ram_wdata),
        .ram_rdata(32'h0), .cpu_hold(p_hold)
    );

    // synchronous single-port RAM model
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            else ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    typedef struct {logic [1:0] id; logic [31:0] data;} rd_t;
    rd_t exp_q [$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[m] = r;
        we[m] = w;
        addr[m] = a;
        wdata[m] = d;
    endtask

    task automatic push(input int id, input logic [31:0] d);
        rd_t e;
        e.id = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_rd(input string tag);
        rd_t e;
        if (exp_q.size() == 0) chk({tag, "_none"}, 32'(rvalid), 32'h0);
        else begin
            e = exp_q.pop_front();
            chk({tag, "_rvalid"}, 32'(rvalid), 32'(3'b001 << e.id));
            chk({tag, "_rdata"}, rdata, e.data);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
        end
        #3;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        next();
        next();
        rst = 1'b0;
        // all masters hold write requests: bubble, then 4-beat bursts in RR order
        set(0, 1, 1, 32'h30, 32'hA0);
        set(1, 1, 1, 32'h31, 32'hA1);
        set(2, 1, 1, 32'h32, 32'hA2);
        #3;
        chk("rr_bubble_gnt", 32'(gnt), 32'h0);
        chk("rr_bubble_hold", 32'(cpu_hold), 32'h1);
        next();
        for (int k = 0; k < 13; k++) begin
            #3;
            chk($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(3'b001 << ((k / 4) % 3)));
            chk($sformatf("rr_addr_%0d", k), ram_addr, 32'h30 + 32'((k / 4) % 3));
            chk($sformatf("rr_hold_%0d", k), 32'(cpu_hold), 32'(((k / 4) % 3) != 0));
            next();
        end
        req = 3'b000;
        #3;
        chk("drop_gnt", 32'(gnt), 32'h0);
        next();
        #3;
        chk("idle_ram_en", 32'(ram_en), 32'h0);
        next();
        // m1 writes then reads 0x10
        set(1, 1, 1, 32'h10, 32'h1234);
        #3;
        chk("t1w_bubble", 32'(gnt), 32'h0);
        next();
        #3;
        chk("t1w_gnt", 32'(gnt), 32'h2);
        chk("t1w_we", 32'(ram_we), 32'h1);
        chk("t1w_addr", ram_addr, 32'h10);
        chk("t1w_wdata", ram_wdata, 32'h1234);
        next();
        req[1] = 1'b0;
        #3;
        chk("t1w_ram_en", 32'(ram_en), 32'h0);
        chk("t1w_rvalid", 32'(rvalid), 32'h0);
        next();
        set(1, 1, 0, 32'h10, 32'h0);
        #3;
        chk("t1r_bubble", 32'(gnt), 32'h0);
        next();
        #3;
        chk("t1r_gnt", 32'(gnt), 32'h2);
        chk("t1r_en", 32'(ram_en), 32'h1);
        chk("t1r_we", 32'(ram_we), 32'h0);
        chk("t1r_addr", ram_addr, 32'h10);
        push(1, 32'h1234);
        next();
        req[1] = 1'b0;
        #3;
        chk_rd("t1r");
        next();
        #3;
        chk("t1r_rvalid_off", 32'(rvalid), 32'h0);
        chk("t1r_rdata_held", rdata, 32'h1234);
        // m2 writes DEADBEEF @0x20, m0 reads it back then 0x10 back-to-back
        set(2, 1, 1, 32'h20, 32'hDEADBEEF);
        #3;
        chk("t4w_bubble", 32'(gnt), 32'h0);
        next();
        #3;
        chk("t4w_gnt", 32'(gnt), 32'h4);
        chk("t4w_we", 32'(ram_we), 32'h1);
        chk("t4w_wdata", ram_wdata, 32'hDEADBEEF);
        next();
        req[2] = 1'b0;
        #3;
        chk("t4w_rvalid", 32'(rvalid), 32'h0);
        chk("t4w_we_off", 32'(ram_we), 32'h0);
        next();
        set(0, 1, 0, 32'h20, 32'h0);
        #3;
        chk("t4r_bubble", 32'(gnt), 32'h0);
        chk("t4r_hold", 32'(cpu_hold), 32'h1);
        next();
        #3;
        chk("t4r_gnt", 32'(gnt), 32'h1);
        chk("t4r_hold_off", 32'(cpu_hold), 32'h0);
        chk("t4r_addr", ram_addr, 32'h20);
        push(0, 32'hDEADBEEF);
        next();
        addr[0] = 32'h10;
        #3;
        chk("b2b_gnt", 32'(gnt), 32'h1);
        chk_rd("t4r");
        push(0, 32'h1234);
        next();
        req[0] = 1'b0;
        #3;
        chk_rd("b2b");
        next();
        // reset during an m0 read burst with a read in flight
        set(0, 1, 0, 32'h20, 32'h0);
        #3;
        chk("t6_bubble", 32'(gnt), 32'h0);
        next();
        #3;
        chk("t6_gnt", 32'(gnt), 32'h1);
        next();
        chk("t6_pre_rvalid", 32'(rvalid), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_rvalid", 32'(rvalid), 32'h0);
        chk("t6_rst_ram_en", 32'(ram_en), 32'h0);
        exp_q.delete();
        next();
        set(1, 1, 0, 32'h10, 32'h0);
        rst = 1'b0;
        #3;
        chk("t6_post_bubble", 32'(gnt), 32'h0);
        next();
        #3;
        chk("t6_post_gnt", 32'(gnt), 32'h1);
        push(0, 32'hDEADBEEF);
        next();
        req = 3'b000;
        #3;
        chk_rd("t6_post");
        next();
        next();
        // CPU priority at idle arbitration vs plain RR (both last_owner=0)
        p_req = 3'b001;
        #3;
        chk("p_bubble0", 32'(p_gnt), 32'h0);
        next();
        #3;
        chk("p_gnt0", 32'(p_gnt), 32'h1);
        next();
        p_req = 3'b000;
        next();
        p_req = 3'b011;
        set(0, 1, 1, 32'h40, 32'h0);
        set(1, 1, 1, 32'h41, 32'h0);
        #3;
        chk("p_bubble", 32'(p_gnt), 32'h0);
        chk("p_bubble_hold", 32'(p_hold), 32'h1);
        next();
        #3;
        chk("p_first", 32'(p_gnt), 32'h1);
        chk("p_hold_off", 32'(p_hold), 32'h0);
        chk("rr_first", 32'(gnt), 32'h2);
        chk("rr_hold", 32'(cpu_hold), 32'h1);
        next();
        p_req = 3'b000;
        req = 3'b000;
        next();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
